// File: rtl/adder_pkg.sv
// Shared types and defaults for the digit-serial adder.
// Holds the FSM state encoding and the default WIDTH/DIGIT values.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Ports: a, b, ci in; s (sum), co (carry out), c_msb (carry into MSB) out.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock, LSB digit first.
// Ports: clk, reset (async high), in_valid/in_ready + a, b, ci
// operand handshake; out_valid/out_ready + sum, co, ovf result
// handshake; busy while running. Defining macro
// DIGIT_SERIAL_ADDER_SUBTRACT_EN adds the sub port (a - b).
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, co_q, ovf_q;
  logic             accept, last, sub_op;
  logic [31:0]      base;
  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_co, dig_cm;

`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  assign last  = (cnt_q == LAST);
  assign base  = 32'(cnt_q) * 32'(DIGIT);
  assign dig_a = a_q[base +: DIGIT];
  assign dig_b = b_q[base +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (dig_a),
    .b     (dig_b),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction stores ~b and forces the initial carry to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub_op ? ~b : b;
      carry_q <= sub_op ? 1'b1 : ci;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[base +: DIGIT] <= dig_s;
      carry_q <= dig_co;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        co_q  <= dig_co;
        ovf_q <= dig_co ^ dig_cm;
      end
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=16, DIGIT=4).
// Honours DIGIT_SERIAL_ADDER_SUBTRACT_EN for the sub port.
module tb_digit_serial_adder;

  localparam int NDIG = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] a, b, sum;
  logic        ci, co, ovf, busy;
  logic        out_valid, out_ready;
  logic        sub_drv = 1'b0;

  res_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   last_acc   = -1;
  bit   b2b        = 1'b0;
  bit   prev_ov    = 1'b0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    .sub       (sub_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on whole words.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] full;
    res_t        r;
    yy    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    r.sum = full[15:0];
    r.co  = full[16];
    r.ovf = (x[15] == yy[15]) && (r.sum[15] != x[15]);
    return r;
  endfunction

  // Monitor: push at acceptance, pop and compare at result handshake.
  initial forever begin
    res_t r;
    @(negedge clk);
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, ci, sub_drv));
        if (b2b && last_acc >= 0)
          chk("b2b_period", cyc + 1 - last_acc, NDIG + 2);
        last_acc = cyc + 1;
      end
      if (out_valid && !prev_ov)
        chk("latency", cyc - last_acc, NDIG);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("sb_sum", sum, r.sum);
          chk("sb_co", co, r.co);
          chk("sb_ovf", ovf, r.ovf);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic c);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    a = x; b = y; ci = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ci = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic directed(input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic [15:0] es,
                          input logic eco, input logic eov);
    out_ready = 1'b1;
    issue(x, y, c);
    wait_done();
    chk("dir_sum", sum, es);
    chk("dir_co", co, eco);
    chk("dir_ovf", ovf, eov);
    @(posedge clk); #1;
    chk("dir_idle", in_ready, 1);
  endtask

  initial begin
    logic [15:0] s0;
    logic        c0, o0;
    int          n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) reset = 1'b0;

    directed(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure, with stray in_valid during RUN and DONE.
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h00F1, 1'b1);
    chk("run_busy", busy, 1);
    in_valid = 1'b1;
    a = 16'hDEAD; b = 16'hBEEF;
    wait_done();
    s0 = sum; c0 = co; o0 = ovf;
    chk("bp_sum", sum, 16'h1001);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", sum, s0);
      chk("bp_hold_co", co, c0);
      chk("bp_hold_ovf", ovf, o0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);

    // Reset in the second RUN cycle aborts the operation.
    issue(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    @(negedge clk) reset = 1'b0;
    directed(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    sub_drv = 1'b1;
    directed(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

    // Random operations with random result backpressure.
    for (int i = 0; i < 40; i++) begin
      sub_drv = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
      sub_drv = 1'($urandom);
`endif
      out_ready = 1'b0;
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    // Back-to-back stream with in_valid held high.
    sub_drv = 1'b0;
    out_ready = 1'b1;
    last_acc = -1;
    b2b = 1'b1;
    in_valid = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of DIGIT and at least DIGIT.
REQ-002 Parameter DIGIT, default 4: bits added per clock cycle; NDIG = WIDTH/DIGIT.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand request.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 ci  in  1  carry-in.
REQ-010 sub  in  1  subtract select; present only when SUBTRACT_EN is defined.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 sum  out  WIDTH  result.
REQ-014 co  out  1  carry-out of the MSB.
REQ-015 ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-016 busy  out  1  high in RUN.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE: on in_valid & in_ready, capture a, b, ci (and sub), clear the digit counter, and go to RUN.
REQ-020 RUN: each cycle adds digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT, LSB digit first) with the registered carry, writes sum digit k, and updates the carry register.
REQ-021 The carry into digit 0 SHALL be the captured ci.
REQ-022 After digit NDIG-1 is processed, the block SHALL latch co and ovf and go to DONE.
REQ-023 Latency: out_valid SHALL rise exactly NDIG cycles after the accepting edge (4 cycles at the defaults).
REQ-024 DONE: sum, co and ovf SHALL hold stable while out_valid & !out_ready; on out_ready, go to IDLE.
REQ-025 Operands are not accepted in the cycle that DONE is left; in_valid seen in DONE or RUN SHALL be ignored.
REQ-026 Input changes on a, b, ci and sub after capture SHALL NOT affect the result in progress.
REQ-027 The counter SHALL wrap at NDIG-1 and never index beyond the operand width.
REQ-028 When NDIG = 1, RUN SHALL last one cycle.

Reset
REQ-029 reset SHALL force IDLE immediately, including mid-RUN or in DONE, aborting the operation.
REQ-030 Reset values: in_ready=1 after the FSM is in IDLE, out_valid=0, busy=0, sum=0, co=0, ovf=0; counter and carry register=0.

Configuration
REQ-031 Macro DIGIT_SERIAL_ADDER_SUBTRACT_EN: when defined, the sub port exists.
REQ-032 With sub=1 captured, the block SHALL compute a - b as a + ~b + 1, ignoring ci; co=1 then means no borrow.
REQ-033 When DIGIT_SERIAL_ADDER_SUBTRACT_EN is not defined, the sub port is absent and the block only adds.

Structure
REQ-034 A shared package adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants.
REQ-035 One sub-module, digit_adder (parameter DIGIT), SHALL be a combinational DIGIT-bit ripple adder built from per-bit full-adder equations.
REQ-036 digit_adder SHALL output the DIGIT-bit sum, the carry-out and the carry into its MSB (used for ovf).

Verification (WIDTH=16, DIGIT=4)
REQ-037 a=0x1234, b=0x1111, ci=0 -> sum=0x2345, co=0, ovf=0, with out_valid exactly 4 cycles after acceptance.
REQ-038 a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, co=0, ovf=1.
REQ-039 Backpressure: out_ready=0 for 5 cycles in DONE -> sum/co/ovf stable, in_ready=0; in_valid pulsed during RUN/DONE is ignored; out_ready=1 -> IDLE next cycle.
REQ-040 reset asserted in the 2nd RUN cycle -> immediate IDLE, out_valid=0, sum=0; a new op 0x0001+0x0001 afterwards -> 0x0002.
REQ-041 With DIGIT_SERIAL_ADDER_SUBTRACT_EN defined: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, co=0; a=0x0007, b=0x0005 -> sum=0x0002, co=1.
REQ-042 Back-to-back: in_valid held high with out_ready=1 -> one operation accepted per NDIG+2 cycles, every result correct.
